// File: rtl/data_memory_seq.sv
// Data/stack RAM for the CPU datapath: clears itself after reset, then serves
// registered reads/writes and a hardware stack growing down from the top word.
module data_memory_seq #(
    parameter int                 DATA_W       = 8,
    parameter int                 ADDR_W       = 8,
    parameter logic [ADDR_W-1:0]  INT_VEC_ADDR = ADDR_W'(1),
    parameter logic [DATA_W-1:0]  INT_VEC_VAL  = DATA_W'(8'h80),
    parameter logic [ADDR_W-1:0]  STACK_MIN    = ADDR_W'(8'hC0)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              push,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              ready,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_MAX;
    localparam logic [ADDR_W-1:0] SP_FULL  = STACK_MIN - ADDR_W'(1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic                stack_err_q, stack_err_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_re;
    logic [ADDR_W-1:0]   mem_raddr;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_ptr_q  <= '0;
            sp_q        <= SP_EMPTY;
            stack_err_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            sp_q        <= sp_d;
            stack_err_q <= stack_err_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Next-state: the clear sequencer walks every address once, then runs.
    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + ADDR_W'(1);
            if (init_ptr_q == ADDR_MAX) begin
                state_d = ST_RUN;
            end
        end
    end

    // Outputs: one memory/stack action per cycle, stack ops win over plain access.
    always_comb begin
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = data_in;
        mem_re      = 1'b0;
        mem_raddr   = addr;
        sp_d        = sp_q;
        stack_err_d = stack_err_q;
        rd_valid_d  = 1'b0;
        data_out_d  = '0;
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = init_ptr_q;
                mem_wdata = (init_ptr_q == INT_VEC_ADDR) ? INT_VEC_VAL : '0;
            end else if (push && pop) begin
                stack_err_d = 1'b1;
            end else if (push) begin
                if (sp_q == SP_FULL) begin
                    stack_err_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = sp_q;
                    sp_d      = sp_q - ADDR_W'(1);
                end
            end else if (pop) begin
                if (sp_q == SP_EMPTY) begin
                    stack_err_d = 1'b1;
                end else begin
                    sp_d       = sp_q + ADDR_W'(1);
                    mem_re     = 1'b1;
                    mem_raddr  = sp_q + ADDR_W'(1);
                    rd_valid_d = 1'b1;
                end
            end else if (mem_write) begin
                mem_we = 1'b1;
                if (mem_read) begin
                    rd_valid_d = 1'b1;
                    data_out_d = data_in;
                end
            end else if (mem_read) begin
                mem_re     = 1'b1;
                rd_valid_d = 1'b1;
            end
        end
    end

    // RAM with registered read port; forwarded or zero data shares the output register.
    // NOTE: the array itself has no reset -- a reset would prevent RAM inference,
    // and the clear sequencer provides the defined contents instead.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
        if (rst) begin
            data_out_q <= '0;
        end else if (mem_re) begin
            data_out_q <= mem_q[mem_raddr];
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign rd_valid  = rd_valid_q;
    assign ready     = (state_q == ST_RUN);
    assign sp        = sp_q;
    assign stack_err = stack_err_q;

endmodule

// File: tb/tb_data_memory_seq.sv
// Directed bench for data_memory_seq: clear sequencer, read/write, stack and
// reset-during-operation scenarios with hand-computed expectations.
module tb_data_memory_seq;

    logic       clk;
    logic       rst;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       push;
    logic       pop;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       ready;
    logic [7:0] sp;
    logic       stack_err;

    int tests_run    = 0;
    int tests_failed = 0;

    data_memory_seq dut (
        .clk       (clk),
        .rst       (rst),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .addr      (addr),
        .data_in   (data_in),
        .push      (push),
        .pop       (pop),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .ready     (ready),
        .sp        (sp),
        .stack_err (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request for exactly one sampling edge, then return to idle.
    task automatic req(input logic r, input logic w, input logic [7:0] a,
                       input logic [7:0] d, input logic pu, input logic po);
        mem_read  = r;
        mem_write = w;
        addr      = a;
        data_in   = d;
        push      = pu;
        pop       = po;
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 8'h00;
        data_in   = 8'h00;
        push      = 1'b0;
        pop       = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 400) begin
            step();
            n++;
        end
    endtask

    task automatic reset_and_init(output int n);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b, expected 0", ready);
        end
        tests_run++;
        if (rd_valid !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: got rd_valid=%b data_out=%h, expected 0/00", rd_valid, data_out);
        end
        tests_run++;
        if (sp !== 8'hFF || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_stack: got sp=%h err=%b, expected ff/0", sp, stack_err);
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        int n;
        wait_ready(n);
        tests_run++;
        if (n !== 256) begin
            tests_failed++;
            $display("FAIL init_latency: got %0d cycles, expected 256", n);
        end
        req(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h80 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_vector: got %h/%b, expected 80/1", data_out, rd_valid);
        end
        req(1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h00 || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL init_clear: got %h/%b, expected 00/1", data_out, rd_valid);
        end
        step();
        tests_run++;
        if (data_out !== 8'h00 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_output: got %h/%b, expected 00/0", data_out, rd_valid);
        end
    endtask

    task automatic test_rw();
        req(1'b0, 1'b1, 8'h10, 8'hAA, 1'b0, 1'b0);
        tests_run++;
        if (rd_valid !== 1'b0 || data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL write_only_out: got %h/%b, expected 00/0", data_out, rd_valid);
        end
        req(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'hAA || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_after_write: got %h/%b, expected aa/1", data_out, rd_valid);
        end
        req(1'b1, 1'b1, 8'h20, 8'hBB, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'hBB || rd_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_first_fwd: got %h/%b, expected bb/1", data_out, rd_valid);
        end
        req(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'hBB) begin
            tests_failed++;
            $display("FAIL fwd_stored: got %h, expected bb", data_out);
        end
        req(1'b0, 1'b1, 8'h10, 8'h55, 1'b0, 1'b0);
        req(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h55) begin
            tests_failed++;
            $display("FAIL overwrite: got %h, expected 55", data_out);
        end
    endtask

    task automatic test_init_ignored();
        int n;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (4) step();
        req(1'b0, 1'b1, 8'h10, 8'h55, 1'b0, 1'b0);
        req(1'b0, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0);
        req(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (rd_valid !== 1'b0 || data_out !== 8'h00 || sp !== 8'hFF) begin
            tests_failed++;
            $display("FAIL init_requests: got rd_valid=%b data_out=%h sp=%h, expected 0/00/ff",
                     rd_valid, data_out, sp);
        end
        wait_ready(n);
        tests_run++;
        if (n !== 249) begin
            tests_failed++;
            $display("FAIL init_ignored_latency: got %0d cycles, expected 249", n);
        end
        req(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL init_write_ignored: got %h, expected 00", data_out);
        end
        req(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h00 || sp !== 8'hFF) begin
            tests_failed++;
            $display("FAIL init_push_ignored: got M[ff]=%h sp=%h, expected 00/ff", data_out, sp);
        end
    endtask

    task automatic test_stack();
        req(1'b0, 1'b0, 8'h00, 8'h42, 1'b1, 1'b0);
        req(1'b0, 1'b0, 8'h00, 8'h43, 1'b1, 1'b0);
        tests_run++;
        if (sp !== 8'hFD || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL push_sp: got sp=%h rd_valid=%b, expected fd/0", sp, rd_valid);
        end
        req(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h42) begin
            tests_failed++;
            $display("FAIL push_mem: got %h, expected 42", data_out);
        end
        req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (data_out !== 8'h43 || rd_valid !== 1'b1 || sp !== 8'hFE) begin
            tests_failed++;
            $display("FAIL pop1: got %h/%b sp=%h, expected 43/1 fe", data_out, rd_valid, sp);
        end
        req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (data_out !== 8'h42 || rd_valid !== 1'b1 || sp !== 8'hFF || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL pop2: got %h/%b sp=%h err=%b, expected 42/1 ff 0",
                     data_out, rd_valid, sp, stack_err);
        end
        req(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (data_out !== 8'h00 || rd_valid !== 1'b0 || sp !== 8'hFF || stack_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow: got %h/%b sp=%h err=%b, expected 00/0 ff 1",
                     data_out, rd_valid, sp, stack_err);
        end
    endtask

    task automatic test_overflow();
        int n;
        reset_and_init(n);
        for (int i = 0; i < 64; i++) begin
            req(1'b0, 1'b0, 8'h00, 8'(i + 1), 1'b1, 1'b0);
        end
        tests_run++;
        if (sp !== 8'hBF || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL stack_fill: got sp=%h err=%b, expected bf/0", sp, stack_err);
        end
        req(1'b0, 1'b0, 8'h00, 8'hEE, 1'b1, 1'b0);
        tests_run++;
        if (sp !== 8'hBF || stack_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow: got sp=%h err=%b, expected bf/1", sp, stack_err);
        end
        req(1'b1, 1'b0, 8'hBF, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL overflow_mem: got %h, expected 00", data_out);
        end
        req(1'b1, 1'b0, 8'hC0, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h40) begin
            tests_failed++;
            $display("FAIL stack_bottom: got %h, expected 40", data_out);
        end
    endtask

    task automatic test_conflict();
        int n;
        reset_and_init(n);
        req(1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0);
        req(1'b1, 1'b0, 8'hFF, 8'h99, 1'b1, 1'b1);
        tests_run++;
        if (rd_valid !== 1'b0 || data_out !== 8'h00 || sp !== 8'hFE || stack_err !== 1'b1) begin
            tests_failed++;
            $display("FAIL push_pop_conflict: got %h/%b sp=%h err=%b, expected 00/0 fe 1",
                     data_out, rd_valid, sp, stack_err);
        end
        req(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h11) begin
            tests_failed++;
            $display("FAIL conflict_mem: got %h, expected 11", data_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        req(1'b0, 1'b1, 8'h10, 8'h99, 1'b0, 1'b0);
        req(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h99) begin
            tests_failed++;
            $display("FAIL pre_reset_write: got %h, expected 99", data_out);
        end
        req(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) step();
        rst = 1'b1;
        step();
        tests_run++;
        if (ready !== 1'b0 || sp !== 8'hFF || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_init_reset: got ready=%b sp=%h err=%b, expected 0/ff/0",
                     ready, sp, stack_err);
        end
        rst = 1'b0;
        wait_ready(n);
        tests_run++;
        if (n !== 256) begin
            tests_failed++;
            $display("FAIL reinit_latency: got %0d cycles, expected 256", n);
        end
        req(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 8'h00 || sp !== 8'hFF || stack_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reinit_state: got M[10]=%h sp=%h err=%b, expected 00/ff/0",
                     data_out, sp, stack_err);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 8'h00;
        data_in   = 8'h00;
        push      = 1'b0;
        pop       = 1'b0;
        test_reset();
        test_init();
        test_rw();
        test_init_ignored();
        test_stack();
        test_overflow();
        test_conflict();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
